// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, syndrome positions and output record for the Hamming(7,4) receive path
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam logic [SYN_W-1:0] SYN_C6 = 3'd7;
    localparam logic [SYN_W-1:0] SYN_C5 = 3'd3;
    localparam logic [SYN_W-1:0] SYN_C4 = 3'd5;
    localparam logic [SYN_W-1:0] SYN_C2 = 3'd6;
    localparam logic [SYN_W-1:0] SYN_C3 = 3'd1;
    localparam logic [SYN_W-1:0] SYN_C1 = 3'd2;
    localparam logic [SYN_W-1:0] SYN_C0 = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              src;
        logic [SYN_W-1:0]  syn;
        logic              corr;
    } out_rec_t;

    // One-hot mask of the codeword bit a nonzero syndrome points at.
    function automatic logic [CODE_W-1:0] syn_to_mask(input logic [SYN_W-1:0] syn);
        logic [CODE_W-1:0] mask;
        mask = '0;
        case (syn)
            SYN_C6:  mask = 7'b100_0000;
            SYN_C5:  mask = 7'b010_0000;
            SYN_C4:  mask = 7'b001_0000;
            SYN_C3:  mask = 7'b000_1000;
            SYN_C2:  mask = 7'b000_0100;
            SYN_C1:  mask = 7'b000_0010;
            SYN_C0:  mask = 7'b000_0001;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/hamming_rx_arbiter_correct.sv
// rtl/hamming_rx_arbiter_correct.sv - hamming74_correct: combinational syndrome, single-bit fix and nibble extraction
module hamming74_correct
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] data_o,
    output logic [SYN_W-1:0]  syn_o,
    output logic              corr_o
);

    logic [CODE_W-1:0] mask;
    logic [CODE_W-1:0] fixed;

    assign syn_o = {code_i[0] ^ code_i[2] ^ code_i[4] ^ code_i[6],
                    code_i[1] ^ code_i[2] ^ code_i[5] ^ code_i[6],
                    code_i[3] ^ code_i[4] ^ code_i[5] ^ code_i[6]};

    // Parity-bit hits still count as a correction even though data is untouched.
    assign mask   = en_i ? syn_to_mask(syn_o) : '0;
    assign fixed  = code_i ^ mask;
    assign data_o = {fixed[6], fixed[5], fixed[4], fixed[2]};
    assign corr_o = en_i & (syn_o != '0);

endmodule

// File: rtl/hamming_rx_arbiter.sv
// rtl/hamming_rx_arbiter.sv - two-channel round-robin Hamming(7,4) decoder; HAMMING_ERR_CNT_EN adds a saturating corrected-error counter
module hamming_rx_arbiter
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in0_valid,
    input  logic [6:0]       in0_code,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [6:0]       in1_code,
    output logic             in1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_src,
    output logic [2:0]       out_syn,
    output logic             out_corr,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic              state_q, state_d;
    out_rec_t          rec_q, rec_d;
    logic              last_q, last_d;
    logic              can_load;
    logic              grant;
    logic              xfer;
    logic [CODE_W-1:0] sel_code;
    logic [DATA_W-1:0] dec_data;
    logic [SYN_W-1:0]  dec_syn;
    logic              dec_corr;

    assign can_load = (state_q == ST_EMPTY) | out_ready;
    // Contention alternates; a lone requester always wins.
    assign grant    = (in0_valid & in1_valid) ? ~last_q : (in1_valid & ~in0_valid);
    assign xfer     = can_load & (in0_valid | in1_valid);
    assign sel_code = grant ? in1_code : in0_code;

    assign in0_ready = can_load & ~grant;
    assign in1_ready = can_load & grant;

    hamming74_correct u_correct (
        .code_i (sel_code),
        .en_i   (en),
        .data_o (dec_data),
        .syn_o  (dec_syn),
        .corr_o (dec_corr)
    );

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        last_d  = last_q;
        if (xfer) begin
            state_d    = ST_FULL;
            rec_d.data = dec_data;
            rec_d.src  = grant;
            rec_d.syn  = dec_syn;
            rec_d.corr = dec_corr;
            last_d     = grant;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rec_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = rec_q.data;
    assign out_src   = rec_q.src;
    assign out_syn   = rec_q.syn;
    assign out_corr  = rec_q.corr;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (xfer && dec_corr && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule
